// File: rtl/riscv_pkg.sv
// Shared opcode constants, FSM/opcode-class enums and the control-strobe bundle
// used by the multi-cycle RV32I sequencer.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } mc_state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ILLEGAL
  } op_class_e;

  // Datapath strobes, in the order they are driven onto the top-level ports.
  typedef struct packed {
    logic pc_write;
    logic pc_branch;
    logic ir_write;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: maps instr[6:0] to the coarse class the
// sequencer needs to choose its EXEC/MEM/WB path.
module mc_opclass
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_R:      op_class = CL_R;
      OP_IMM:    op_class = CL_IMM;
      OP_LOAD:   op_class = CL_LOAD;
      OP_STORE:  op_class = CL_STORE;
      OP_BRANCH: op_class = CL_BRANCH;
      default:   op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and handshakes with the shared memory via mem_ready.
module mc_controller
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_branch,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  mc_state_e       state_q, state_d;
  op_class_e       op_q;
  op_class_e       dec_class;
  mc_ctrl_t        ctrl;
  logic            retire;
  logic            illegal_q;
  logic [XLEN-1:0] instret_q;

  mc_opclass u_opclass (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = ST_DECODE;
        end
      end
      // The only state that looks at the raw opcode; later states use op_q.
      ST_DECODE: state_d = (dec_class == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        ctrl.alu_src = op_q inside {CL_IMM, CL_LOAD, CL_STORE};
        case (op_q)
          CL_R, CL_IMM:      state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH: begin
            ctrl.pc_branch = 1'b1;
            retire         = 1'b1;
            state_d        = ST_FETCH;
          end
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        ctrl.iord    = 1'b1;
        ctrl.alu_src = 1'b1;
        case (op_q)
          CL_LOAD: begin
            ctrl.mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end
          CL_STORE: begin
            ctrl.mem_write = 1'b1;
            if (mem_ready) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (op_q == CL_LOAD);
        retire          = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= CL_ILLEGAL;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= dec_class;
      if (retire) instret_q <= instret_q + XLEN'(1);
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  // Reset masks every output so nothing leaks while the core is held.
  assign {pc_write, pc_branch, ir_write, mem_read, mem_write,
          iord, alu_src, mem_to_reg, reg_write} = rst_n ? ctrl : '0;
  assign illegal = rst_n & illegal_q;
  assign instret = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed per-cycle vector table,
// hand-written reset/trap sequences and a randomized instruction-level model.
module tb_mc_controller;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] BAD_OP = 7'b1111111;

  // Strobe masks in port order: pc_write .. reg_write.
  localparam logic [8:0] S_PCW  = 9'h100;
  localparam logic [8:0] S_PCB  = 9'h080;
  localparam logic [8:0] S_IRW  = 9'h040;
  localparam logic [8:0] S_MRD  = 9'h020;
  localparam logic [8:0] S_MWR  = 9'h010;
  localparam logic [8:0] S_IORD = 9'h008;
  localparam logic [8:0] S_ALU  = 9'h004;
  localparam logic [8:0] S_M2R  = 9'h002;
  localparam logic [8:0] S_RW   = 9'h001;
  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_FRDY = S_PCW | S_IRW | S_MRD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_branch, ir_write, mem_read, mem_write;
  logic        iord, alu_src, mem_to_reg, reg_write, illegal;
  logic [31:0] instret;
  logic [8:0]  strb;

  assign strb = {pc_write, pc_branch, ir_write, mem_read, mem_write,
                 iord, alu_src, mem_to_reg, reg_write};

  mc_controller #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_branch  (pc_branch),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_ret;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [8:0]  strb;
    logic [31:0] ret;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [6:0] op, input logic rdy, input logic [8:0] s,
                              input logic [31:0] ret, input logic ill);
    vec_t v;
    v.op = op; v.rdy = rdy; v.strb = s; v.ret = ret; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge: drive, sample 1 unit later, advance to the next falling edge.
  task automatic cyc(input logic [6:0] op, input logic rdy, input logic [8:0] exp_s,
                     input logic [31:0] exp_ret, input logic exp_ill, input string name);
    opcode    = op;
    mem_ready = rdy;
    #1;
    check({name, " strobes"}, 64'(strb), 64'(exp_s));
    check({name, " instret"}, 64'(instret), 64'(exp_ret));
    check({name, " illegal"}, 64'(illegal), 64'(exp_ill));
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_n     = 1'b0;
    opcode    = 7'($urandom);
    mem_ready = 1'b1;
    #1;
    check({name, " reset strobes+illegal"}, 64'({strb, illegal}), 64'd0);
    check({name, " reset instret"}, 64'(instret), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_ret = '0;
  endtask

  // Instruction-level reference: expected strobes per phase of one instruction.
  task automatic run_rand_instr(input int idx);
    int         k, fw, mw;
    logic [6:0] op;
    bit         is_ld, is_st, is_br, is_bad, uses_imm;
    logic [8:0] req;
    string      nm;
    nm = $sformatf("rnd%0d", idx);
    k  = $urandom_range(0, 19);
    is_bad = 0;
    if      (k < 4)  op = R_OP;
    else if (k < 8)  op = I_OP;
    else if (k < 12) op = LD_OP;
    else if (k < 16) op = ST_OP;
    else if (k < 19) op = BR_OP;
    else begin
      is_bad = 1;
      do op = 7'($urandom); while (op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP});
    end
    is_ld    = (op == LD_OP);
    is_st    = (op == ST_OP);
    is_br    = (op == BR_OP);
    uses_imm = (op == I_OP) || is_ld || is_st;
    fw = $urandom_range(0, 2);
    mw = $urandom_range(0, 2);

    for (int i = 0; i < fw; i++) cyc(7'($urandom), 1'b0, S_MRD, model_ret, 1'b0, {nm, " fetch-wait"});
    cyc(7'($urandom), 1'b1, S_FRDY, model_ret, 1'b0, {nm, " fetch"});
    cyc(op, 1'($urandom), S_NONE, model_ret, 1'b0, {nm, " decode"});
    if (is_bad) begin
      for (int i = 0; i < 3; i++) cyc(7'($urandom), 1'($urandom), S_NONE, model_ret, 1'b1, {nm, " trap"});
      do_reset({nm, " trap-exit"});
      return;
    end
    cyc(7'($urandom), 1'($urandom), (uses_imm ? S_ALU : S_NONE) | (is_br ? S_PCB : S_NONE),
        model_ret, 1'b0, {nm, " exec"});
    if (is_br) begin
      model_ret++;
      return;
    end
    if (is_ld || is_st) begin
      req = (is_ld ? S_MRD : S_MWR) | S_IORD | S_ALU;
      for (int i = 0; i < mw; i++) cyc(7'($urandom), 1'b0, req, model_ret, 1'b0, {nm, " mem-wait"});
      cyc(7'($urandom), 1'b1, req, model_ret, 1'b0, {nm, " mem"});
      if (is_st) begin
        model_ret++;
        return;
      end
    end
    cyc(7'($urandom), 1'($urandom), S_RW | (is_ld ? S_M2R : S_NONE), model_ret, 1'b0, {nm, " wb"});
    model_ret++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed stream: R, LOAD (2 MEM waits), STORE (3 fetch stalls), BRANCH, next FETCH.
    tbl.push_back(mk(R_OP,  1, S_FRDY, 0, 0));
    tbl.push_back(mk(R_OP,  0, S_NONE, 0, 0));
    tbl.push_back(mk(R_OP,  1, S_NONE, 0, 0));
    tbl.push_back(mk(R_OP,  0, S_RW,   0, 0));
    tbl.push_back(mk(LD_OP, 1, S_FRDY, 1, 0));
    tbl.push_back(mk(LD_OP, 1, S_NONE, 1, 0));
    tbl.push_back(mk(LD_OP, 1, S_ALU,  1, 0));
    tbl.push_back(mk(LD_OP, 0, S_MRD | S_IORD | S_ALU, 1, 0));
    tbl.push_back(mk(LD_OP, 0, S_MRD | S_IORD | S_ALU, 1, 0));
    tbl.push_back(mk(LD_OP, 1, S_MRD | S_IORD | S_ALU, 1, 0));
    tbl.push_back(mk(LD_OP, 1, S_RW | S_M2R, 1, 0));
    tbl.push_back(mk(ST_OP, 0, S_MRD,  2, 0));
    tbl.push_back(mk(ST_OP, 0, S_MRD,  2, 0));
    tbl.push_back(mk(ST_OP, 0, S_MRD,  2, 0));
    tbl.push_back(mk(ST_OP, 1, S_FRDY, 2, 0));
    tbl.push_back(mk(ST_OP, 1, S_NONE, 2, 0));
    tbl.push_back(mk(ST_OP, 0, S_ALU,  2, 0));
    tbl.push_back(mk(ST_OP, 1, S_MWR | S_IORD | S_ALU, 2, 0));
    tbl.push_back(mk(BR_OP, 1, S_FRDY, 3, 0));
    tbl.push_back(mk(BR_OP, 1, S_NONE, 3, 0));
    tbl.push_back(mk(BR_OP, 1, S_PCB,  3, 0));
    tbl.push_back(mk(BR_OP, 0, S_MRD,  4, 0));

    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;
    model_ret = '0;
    @(negedge clk);
    do_reset("init");
    foreach (tbl[i]) cyc(tbl[i].op, tbl[i].rdy, tbl[i].strb, tbl[i].ret, tbl[i].ill,
                         $sformatf("vec%0d", i));

    // Illegal opcode: trap for 20 cycles, then reset clears the sticky flag.
    do_reset("pre-trap");
    cyc(BAD_OP, 1'b1, S_FRDY, 0, 1'b0, "trap fetch");
    cyc(BAD_OP, 1'b0, S_NONE, 0, 1'b0, "trap decode");
    for (int i = 0; i < 20; i++) cyc(7'($urandom), 1'($urandom), S_NONE, 0, 1'b1, "trap hold");
    do_reset("trap-clear");
    cyc(R_OP, 1'b0, S_MRD, 0, 1'b0, "post-trap fetch");

    // Reset during a LOAD memory wait: partial instruction is dropped.
    do_reset("pre-abort");
    cyc(R_OP,  1'b1, S_FRDY, 0, 1'b0, "abort R fetch");
    cyc(R_OP,  1'b1, S_NONE, 0, 1'b0, "abort R decode");
    cyc(R_OP,  1'b1, S_NONE, 0, 1'b0, "abort R exec");
    cyc(R_OP,  1'b1, S_RW,   0, 1'b0, "abort R wb");
    cyc(LD_OP, 1'b1, S_FRDY, 1, 1'b0, "abort LD fetch");
    cyc(LD_OP, 1'b1, S_NONE, 1, 1'b0, "abort LD decode");
    cyc(LD_OP, 1'b1, S_ALU,  1, 1'b0, "abort LD exec");
    cyc(LD_OP, 1'b0, S_MRD | S_IORD | S_ALU, 1, 1'b0, "abort LD mem-wait");
    do_reset("abort");
    for (int i = 0; i < 4; i++) cyc(LD_OP, 1'b0, S_MRD, 0, 1'b0, "abort refetch");

    // Randomized instruction stream against the phase-level model.
    do_reset("random");
    for (int i = 0; i < 300; i++) run_rand_instr(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencer for the RV32I core datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Issues per-state datapath strobes (PC/IR write, ALU source, memory read/write, register write) and waits on a shared memory ready handshake. Sits between the instruction register and the shared single-port memory, replacing per-opcode static control with timed control.

## Interface
- `XLEN`, default 32: width of the retired-instruction counter.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset; one clock, and reset is synchronous and active-low.
- `opcode` input 7: instr[6:0] from the IR; valid from DECODE onward.
- `mem_ready` input 1: memory completed the current read/write this cycle.
- `pc_write` output 1: PC <= PC+4.
- `pc_branch` output 1: PC <= branch target if ALU zero (datapath qualifies).
- `ir_write` output 1: latch fetched word into IR.
- `mem_read` output 1: memory read request (fetch or load).
- `mem_write` output 1: memory write request (store).
- `iord` output 1: 0 = address from PC, 1 = address from ALU result.
- `alu_src` output 1: 0 = rs2, 1 = immediate.
- `mem_to_reg` output 1: writeback source is memory data.
- `reg_write` output 1: register file write enable.
- `illegal` output 1: sticky; unsupported opcode decoded.
- `instret` output XLEN: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH; `instret`=0, `illegal`=0.
- FETCH: `mem_read`=1, `iord`=0. Hold until `mem_ready`. In the ready cycle, pulse `ir_write` and `pc_write`, then go to DECODE.
- DECODE: latch `opcode` into `op_q` and classify it.
  - R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011) and BRANCH (1100011) go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC:
  - `alu_src`=1 for I-ALU, LOAD and STORE; 0 otherwise.
  - R and I-ALU go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH pulses `pc_branch` and `instret`++, then goes to FETCH.
- MEM: `iord`=1, `alu_src`=1.
  - LOAD: `mem_read`=1 until `mem_ready`, then go to WB.
  - STORE: `mem_write`=1 until `mem_ready`; in the ready cycle `instret`++, then go to FETCH.
- WB: `reg_write`=1 for one cycle; `mem_to_reg`=1 only for LOAD; `instret`++; then go to FETCH.
- TRAP: set `illegal`; all strobes 0; stay until reset.
- `mem_read` and `mem_write` are never asserted together.
- `reg_write`, `pc_write`, `pc_branch` and `ir_write` are each asserted for at most one cycle per instruction.
- `instret` wraps modulo 2^XLEN.

## Timing
- Outputs are combinational from the registered state, `op_q` and `mem_ready`. No output depends on `opcode` outside DECODE.
- While `rst_n`=0, all outputs are forced to 0 regardless of state. The first cycle after release is FETCH with `mem_read`=1.
- Zero-wait latency (cycles per instruction):
  - BRANCH: 3.
  - R, I-ALU, STORE: 4.
  - LOAD: 5.
  - Each wait cycle on `mem_ready` adds 1.
- `mem_ready` is ignored outside FETCH and MEM.
- Reset asserted mid-instruction, including during a memory wait, returns the block to FETCH on the next edge. The partial instruction is not counted and not retried.
- Request stability: once `mem_read` or `mem_write` is asserted, it and `iord` stay stable until the `mem_ready` cycle.

## Structure
- `riscv_pkg` holds:
  - opcode localparams `OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`;
  - `mc_state_e` enum (3-bit);
  - `op_class_e` enum (R, IMM, LOAD, STORE, BRANCH, ILLEGAL).
- Sub-module `mc_opclass`: combinational opcode to `op_class_e`, instantiated once in DECODE.
- One state register, one `op_q` register (holds `op_class_e`), plus the `instret` and `illegal` registers.

## Test plan
- Reset then R-type (0110011), `mem_ready` tied 1:
  - `ir_write`/`pc_write` in cycle 1;
  - `reg_write`=1, `mem_to_reg`=0 in cycle 4;
  - `instret`=1.
- LOAD (0000011) with `mem_ready` low for 2 cycles in MEM:
  - `mem_read`=1 with `iord`=1 held for 3 cycles;
  - `reg_write`=1 with `mem_to_reg`=1 in cycle 7.
- STORE (0100011), fetch stalled 3 cycles:
  - `ir_write` only in the ready cycle;
  - `mem_write` asserted once in MEM;
  - `reg_write` never asserted;
  - next FETCH starts at cycle 8.
- BRANCH (1100011): `pc_branch` pulses in cycle 3, then FETCH in cycle 4, with no `reg_write`.
- Opcode 1111111: TRAP entered after DECODE; `illegal`=1 and all strobes 0 for 20 cycles; `rst_n` low clears it.
- `rst_n` pulsed low during a LOAD MEM wait: next cycle is FETCH, `instret` is 0, and no `reg_write` occurs.
